// File: rtl/fb_fill_arbiter.sv
// Shares DPRAM port 0 between the processor pixel interface and a rectangle-fill engine.
// The processor always wins; the engine writes one pixel on every cycle the processor leaves idle.
module fb_fill_arbiter #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int ADDR_W  = 19,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic               cpu_din,
    input  logic               cpu_we,
    output logic               cpu_dout,
    input  logic               cmd_start,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic               cmd_color,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_din,
    output logic               ram_we,
    input  logic               ram_dout
);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, FINISH} state_t;

    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(WIDTH);

    state_t               state_reg;
    logic [COORD_W-1:0]   x0_reg, x1_reg, y0_reg, y1_reg;
    logic                 color_reg;
    logic [COORD_W-1:0]   x_reg, y_reg;
    logic [ADDR_W-1:0]    row_base_reg;
    logic                 busy_reg, done_reg, err_reg;

    logic [COORD_W-1:0]   x1_clip, y1_clip;
    logic                 empty;
    logic [ADDR_W-1:0]    eng_addr;
    logic                 eng_wr;
    logic                 last_px;

    // Out-of-range starts are caught here too, so row_base can never exceed the frame.
    assign x1_clip  = (x1_reg > X_MAX) ? X_MAX : x1_reg;
    assign y1_clip  = (y1_reg > Y_MAX) ? Y_MAX : y1_reg;
    assign empty    = (x0_reg > x1_clip) || (y0_reg > y1_clip) ||
                      (x0_reg > X_MAX)   || (y0_reg > Y_MAX);
    assign eng_addr = row_base_reg + ADDR_W'(x_reg);
    assign eng_wr   = (state_reg == FILL) && !cpu_req;
    // x1_reg/y1_reg hold the clipped bounds once LOAD has run.
    assign last_px  = (x_reg == x1_reg) && (y_reg == y1_reg);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            x_reg        <= '0;
            y_reg        <= '0;
            row_base_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_start) begin
                        x0_reg    <= cmd_x0;
                        x1_reg    <= cmd_x1;
                        y0_reg    <= cmd_y0;
                        y1_reg    <= cmd_y1;
                        color_reg <= cmd_color;
                        busy_reg  <= 1'b1;
                        err_reg   <= 1'b0;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    x1_reg       <= x1_clip;
                    y1_reg       <= y1_clip;
                    x_reg        <= x0_reg;
                    y_reg        <= y0_reg;
                    row_base_reg <= ADDR_W'(y0_reg) * ROW_STEP;
                    if (empty) begin
                        err_reg   <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        state_reg <= FILL;
                    end
                end
                FILL: begin
                    if (!cpu_req) begin
                        if (last_px) begin
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end else if (x_reg == x1_reg) begin
                            x_reg        <= x0_reg;
                            y_reg        <= y_reg + COORD_W'(1);
                            row_base_reg <= row_base_reg + ROW_STEP;
                        end else begin
                            x_reg <= x_reg + COORD_W'(1);
                        end
                    end
                end
                FINISH: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_req & cpu_we;
        if (eng_wr) begin
            ram_addr = eng_addr;
            ram_din  = color_reg;
            ram_we   = 1'b1;
        end
    end

    assign cpu_dout  = ram_dout;
    assign cmd_ready = (state_reg == IDLE);
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: doc/fb_fill_arbiter.md
Name: fb_fill_arbiter

Overview:
- Shares port 0 of the 640x480x1 pixel DPRAM between the processor's pixel interface and a hardware rectangle-fill engine.
- The processor has absolute priority. The fill engine writes one pixel per idle cycle.
- Sits between the processor's pixelAddr/pixelIn/pixelWe/pixelOut signals and DPRAM port 0 (addr0/dataIn0/wEn0/dataOut0), on the processor clock domain.
- Lets software clear the screen or draw boxes with one command instead of 307200 stores.

Parameters:
- WIDTH, 640, pixels per row.
- HEIGHT, 480, rows.
- ADDR_W, 19, pixel address width.
- COORD_W, 10, coordinate width.

Ports:
- clk  in  1  processor clock.
- resetn  in  1  synchronous active-low reset.
- cpu_req  in  1  processor accesses the pixel RAM this cycle (read or write).
- cpu_addr  in  ADDR_W  processor pixel address.
- cpu_din  in  1  processor write data.
- cpu_we  in  1  processor write enable (only meaningful with cpu_req).
- cpu_dout  out  1  read data to processor.
- cmd_start  in  1  fill command strobe.
- cmd_ready  out  1  engine can accept a command.
- cmd_x0, cmd_x1  in  COORD_W  inclusive column bounds.
- cmd_y0, cmd_y1  in  COORD_W  inclusive row bounds.
- cmd_color  in  1  fill value.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky: last command was empty after clipping. Cleared by the next accepted command.
- ram_addr  out  ADDR_W  to DPRAM addr0.
- ram_din  out  1  to DPRAM dataIn0.
- ram_we  out  1  to DPRAM wEn0.
- ram_dout  in  1  from DPRAM dataOut0.

Behaviour:
- Reset (clk edge with resetn=0): state IDLE; busy=0, done=0, err=0; internal x, y and row_base cleared.
  - Reset mid-fill aborts the command with no done pulse. Pixels already written stay written.
- States:
  - IDLE -> LOAD on cmd_start.
  - LOAD -> FILL if the clipped rectangle is non-empty; LOAD -> FINISH with err=1 if empty.
  - FILL -> FINISH after the last pixel is written.
  - FINISH -> IDLE.
- cmd_ready = (state==IDLE). cmd_start while not ready is ignored; the command is not queued.
- Acceptance: in IDLE with cmd_start=1, register all cmd_* fields and set busy=1.
- LOAD (1 cycle):
  - Clip x1 to min(x1, WIDTH-1) and y1 to min(y1, HEIGHT-1).
  - Empty if x0>x1c, y0>y1c, x0>=WIDTH or y0>=HEIGHT.
  - Set x=x0, y=y0, row_base=y0*WIDTH (one multiply, or a constant-shift sum 512+128).
- FILL:
  - Engine pixel address = row_base + x.
  - Each cycle with cpu_req=0: write the pixel and advance.
  - Advance: if x==x1c, then x=x0, y=y+1, row_base += WIDTH; otherwise x=x+1.
  - Cycle with cpu_req=1: engine holds all counters and performs no write.
  - Write of (x1c, y1c) -> FINISH.
- FINISH: done=1 for exactly this cycle; busy=0 from the next cycle.
- Port mux (combinational):
  - If state==FILL and cpu_req=0: ram_addr=engine address, ram_din=cmd_color, ram_we=1.
  - Otherwise: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_req&cpu_we.
  - ram_we is never 1 in IDLE, LOAD or FINISH unless driven by the processor.
- cpu_dout = ram_dout, passed through unchanged.
  - Read latency is unchanged: 1 clock from the address.
  - The processor's read data is not corrupted by engine activity. The processor reads stale-vs-new data under its own ordering; no coherency logic.
- Throughput: W*H pixels take W*H + (cpu_req cycles during FILL) + 3 cycles from start to done.
- Width rules: row_base is ADDR_W bits; the maximum value 479*640+639 = 307199 fits in 19 bits. No wrap is possible after clipping.

Test Plan:
- Fill (1,1)-(2,2), color=1, cpu_req=0:
  - ram_we=1 with addresses 641, 642, 1281, 1282 on consecutive cycles starting 2 cycles after the start edge.
  - done pulse on the following cycle; busy drops after it; err=0.
- Same fill with cpu_req=1 on the second FILL cycle (cpu_we=1, addr=5, din=0):
  - That cycle shows ram_addr=5, ram_din=0.
  - Engine writes 642 on the next cycle; done is delayed by exactly 1 cycle.
- Fill (638,478)-(900,700):
  - Clipped to writes 306558, 306559, 307198, 307199 (in that order), then done; err=0.
- Fill x0=5, x1=3:
  - No ram_we from the engine; done 2 cycles after start; err=1.
  - A subsequent valid command clears err.
- cmd_start while busy: ignored; the original rectangle completes unchanged and only one done pulse occurs.
- resetn=0 for one cycle mid-fill:
  - Next cycle busy=0, done=0, cmd_ready=1, and no further engine writes.
  - A new command then executes normally.
